// File: rtl/lock_ctrl.sv
// Keypad lock controller: checks entered 4-digit BCD codes against a stored password,
// handles lockout after repeated failures, auto-relock, and two-step password change.
module lock_ctrl #(
   parameter logic [15:0] DEFAULT_PWD    = 16'h1234,
   parameter int          MAX_FAIL       = 3,
   parameter int          LOCKOUT_CYCLES = 50_000_000,
   parameter int          UNLOCK_CYCLES  = 250_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        entry_done,
   input  logic [15:0] entry_code,
   input  logic        set_req,
   input  logic        lock_req,
   output logic        entry_clr,
   output logic        unlocked,
   output logic        alarm,
   output logic [1:0]  fail_cnt,
   output logic [2:0]  state
);

   localparam int          UW     = $clog2(UNLOCK_CYCLES + 1);
   localparam int          LW     = $clog2(LOCKOUT_CYCLES + 1);
   localparam logic [1:0]  MAX_F  = 2'(MAX_FAIL);
   localparam logic [UW-1:0] RELOCK_LOAD  = UW'(UNLOCK_CYCLES - 1);
   localparam logic [LW-1:0] LOCKOUT_LOAD = LW'(LOCKOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_LOCKED = 3'd0,
      S_CHECK  = 3'd1,
      S_OPEN   = 3'd2,
      S_SET1   = 3'd3,
      S_SET2   = 3'd4,
      S_ALARM  = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      fail_q, fail_d;
   logic [15:0]     pwd_q, pwd_d;
   logic [15:0]     cap_q, cap_d;
   logic [15:0]     new_q, new_d;
   logic [UW-1:0]   relock_q, relock_d;
   logic [LW-1:0]   lockout_q, lockout_d;
   logic            clr_q, clr_d;
   logic [1:0]      fail_inc;

   // Unentered digits arrive padded with 4'hF, so any nibble above 9 invalidates the code.
   function automatic logic code_valid(input logic [15:0] c);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c[i*4 +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   assign fail_inc = (fail_q >= MAX_F) ? MAX_F : fail_q + 2'd1;

   always_comb begin
      state_d   = state_q;
      fail_d    = fail_q;
      pwd_d     = pwd_q;
      cap_d     = cap_q;
      new_d     = new_q;
      clr_d     = 1'b0;
      relock_d  = (relock_q == '0) ? '0 : relock_q - UW'(1);
      lockout_d = (lockout_q == '0) ? '0 : lockout_q - LW'(1);

      case (state_q)
         S_LOCKED: begin
            if (entry_done) begin
               cap_d   = entry_code;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            clr_d = 1'b1;
            if (code_valid(cap_q) && (cap_q == pwd_q)) begin
               state_d  = S_OPEN;
               fail_d   = 2'd0;
               relock_d = RELOCK_LOAD;
            end else begin
               fail_d = fail_inc;
               if (fail_inc == MAX_F) begin
                  state_d   = S_ALARM;
                  lockout_d = LOCKOUT_LOAD;
               end else begin
                  state_d = S_LOCKED;
               end
            end
         end
         S_OPEN: begin
            if (lock_req || (relock_q == '0)) begin
               state_d = S_LOCKED;
            end else if (set_req) begin
               state_d = S_SET1;
               clr_d   = 1'b1;
            end
         end
         S_SET1: begin
            relock_d = relock_q;
            if (entry_done) begin
               clr_d = 1'b1;
               if (code_valid(entry_code)) begin
                  new_d   = entry_code;
                  state_d = S_SET2;
               end else begin
                  state_d  = S_OPEN;
                  relock_d = RELOCK_LOAD;
               end
            end
         end
         S_SET2: begin
            relock_d = relock_q;
            if (entry_done) begin
               clr_d    = 1'b1;
               state_d  = S_OPEN;
               relock_d = RELOCK_LOAD;
               if (entry_code == new_q) pwd_d = new_q;
            end
         end
         S_ALARM: begin
            if (lockout_q == '0) begin
               state_d = S_LOCKED;
               fail_d  = 2'd0;
            end
         end
         default: state_d = S_LOCKED;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_LOCKED;
         fail_q    <= 2'd0;
         pwd_q     <= DEFAULT_PWD;
         cap_q     <= 16'd0;
         new_q     <= 16'd0;
         relock_q  <= '0;
         lockout_q <= '0;
         clr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         fail_q    <= fail_d;
         pwd_q     <= pwd_d;
         cap_q     <= cap_d;
         new_q     <= new_d;
         relock_q  <= relock_d;
         lockout_q <= lockout_d;
         clr_q     <= clr_d;
      end
   end

   assign state     = state_q;
   assign fail_cnt  = fail_q;
   assign entry_clr = clr_q;
   assign alarm     = (state_q == S_ALARM);
   assign unlocked  = (state_q == S_OPEN) || (state_q == S_SET1) || (state_q == S_SET2);

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl with short timers (lockout 8, relock 16 cycles).
module tb_lock_ctrl;

   localparam logic [2:0] LOCKED = 3'd0, CHECK = 3'd1, OPEN = 3'd2,
                          SET1 = 3'd3, SET2 = 3'd4, ALARM = 3'd5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        entry_done = 1'b0;
   logic [15:0] entry_code = 16'd0;
   logic        set_req = 1'b0;
   logic        lock_req = 1'b0;
   logic        entry_clr, unlocked, alarm;
   logic [1:0]  fail_cnt;
   logic [2:0]  state;

   int checks = 0;
   int failures = 0;

   lock_ctrl #(
      .DEFAULT_PWD(16'h1234), .MAX_FAIL(3), .LOCKOUT_CYCLES(8), .UNLOCK_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst), .entry_done(entry_done), .entry_code(entry_code),
      .set_req(set_req), .lock_req(lock_req), .entry_clr(entry_clr),
      .unlocked(unlocked), .alarm(alarm), .fail_cnt(fail_cnt), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_done(input logic [15:0] code);
      entry_done = 1'b1;
      entry_code = code;
      tick();
      entry_done = 1'b0;
   endtask

   task automatic pulse_set();
      set_req = 1'b1;
      tick();
      set_req = 1'b0;
   endtask

   task automatic pulse_lock();
      lock_req = 1'b1;
      tick();
      lock_req = 1'b0;
   endtask

   // Full code attempt from LOCKED: entry, one CHECK cycle, then the decision state.
   task automatic attempt(input logic [15:0] code);
      pulse_done(code);
      tick();
   endtask

   initial begin
      #2;
      chk("rst_state", 32'(state), 32'(LOCKED));
      chk("rst_fail", 32'(fail_cnt), 0);
      chk("rst_unlocked", 32'(unlocked), 0);
      chk("rst_alarm", 32'(alarm), 0);
      chk("rst_clr", 32'(entry_clr), 0);
      #10 rst = 1'b1;
      tick();
      chk("idle_locked", 32'(state), 32'(LOCKED));

      // Correct code: CHECK after one cycle, OPEN with entry_clr after two.
      pulse_done(16'h1234);
      chk("ok_check", 32'(state), 32'(CHECK));
      tick();
      chk("ok_open", 32'(state), 32'(OPEN));
      chk("ok_unlocked", 32'(unlocked), 1);
      chk("ok_clr", 32'(entry_clr), 1);
      chk("ok_fail", 32'(fail_cnt), 0);
      tick();
      chk("ok_clr_once", 32'(entry_clr), 0);
      pulse_lock();
      chk("lock_req", 32'(state), 32'(LOCKED));

      // Three wrong codes lead to ALARM for 8 cycles.
      attempt(16'h0000);
      chk("bad1_state", 32'(state), 32'(LOCKED));
      chk("bad1_fail", 32'(fail_cnt), 1);
      chk("bad1_clr", 32'(entry_clr), 1);
      attempt(16'h0000);
      chk("bad2_fail", 32'(fail_cnt), 2);
      attempt(16'h0000);
      chk("bad3_state", 32'(state), 32'(ALARM));
      chk("bad3_alarm", 32'(alarm), 1);
      chk("bad3_fail", 32'(fail_cnt), 3);
      entry_done = 1'b1;
      entry_code = 16'h1234;
      for (int i = 1; i < 8; i++) begin
         tick();
         chk($sformatf("alarm_hold%0d", i), 32'(state), 32'(ALARM));
      end
      entry_done = 1'b0;
      tick();
      chk("alarm_end_state", 32'(state), 32'(LOCKED));
      chk("alarm_end_fail", 32'(fail_cnt), 0);
      chk("alarm_end_alarm", 32'(alarm), 0);
      tick();
      chk("alarm_entry_ignored", 32'(state), 32'(LOCKED));

      // Password change to 5678.
      attempt(16'h1234);
      pulse_set();
      chk("set1_state", 32'(state), 32'(SET1));
      chk("set1_clr", 32'(entry_clr), 1);
      chk("set1_unlocked", 32'(unlocked), 1);
      pulse_done(16'h5678);
      chk("set2_state", 32'(state), 32'(SET2));
      chk("set2_clr", 32'(entry_clr), 1);
      pulse_done(16'h5678);
      chk("set_done_state", 32'(state), 32'(OPEN));
      chk("set_done_clr", 32'(entry_clr), 1);
      pulse_lock();
      attempt(16'h5678);
      chk("new_pwd_open", 32'(state), 32'(OPEN));
      pulse_lock();
      attempt(16'h1234);
      chk("old_pwd_state", 32'(state), 32'(LOCKED));
      chk("old_pwd_fail", 32'(fail_cnt), 1);
      attempt(16'h5678);
      chk("restore_open", 32'(state), 32'(OPEN));
      chk("restore_fail", 32'(fail_cnt), 0);
      pulse_set();
      pulse_done(16'h1234);
      pulse_done(16'h1234);
      pulse_lock();

      // Invalid SET1 code and SET2 mismatch both leave the password alone.
      attempt(16'h1234);
      chk("back_1234_open", 32'(state), 32'(OPEN));
      pulse_set();
      pulse_done(16'h12FF);
      chk("pad_set1_open", 32'(state), 32'(OPEN));
      chk("pad_set1_clr", 32'(entry_clr), 1);
      pulse_set();
      pulse_done(16'h4321);
      chk("mm_set2", 32'(state), 32'(SET2));
      pulse_done(16'h4320);
      chk("mm_open", 32'(state), 32'(OPEN));
      pulse_lock();
      attempt(16'h4321);
      chk("mm_4321_rejected", 32'(state), 32'(LOCKED));
      attempt(16'h1234);
      chk("mm_1234_kept", 32'(state), 32'(OPEN));
      chk("mm_fail_clr", 32'(fail_cnt), 0);

      // Relock timeout: OPEN lasts exactly 16 cycles.
      for (int i = 1; i < 16; i++) tick();
      chk("timeout_still_open", 32'(state), 32'(OPEN));
      tick();
      chk("timeout_locked", 32'(state), 32'(LOCKED));

      // lock_req outranks set_req.
      attempt(16'h1234);
      set_req  = 1'b1;
      lock_req = 1'b1;
      tick();
      set_req  = 1'b0;
      lock_req = 1'b0;
      chk("lock_over_set", 32'(state), 32'(LOCKED));

      // Asynchronous reset during ALARM.
      attempt(16'h0000);
      attempt(16'h0000);
      attempt(16'h0000);
      chk("pre_rst_alarm", 32'(state), 32'(ALARM));
      rst = 1'b0;
      #1;
      chk("rst_alarm_state", 32'(state), 32'(LOCKED));
      chk("rst_alarm_alarm", 32'(alarm), 0);
      chk("rst_alarm_fail", 32'(fail_cnt), 0);
      #1 rst = 1'b1;
      tick();

      // Asynchronous reset during SET2 keeps the default password.
      attempt(16'h1234);
      pulse_set();
      pulse_done(16'h4321);
      chk("pre_rst_set2", 32'(state), 32'(SET2));
      rst = 1'b0;
      #1;
      chk("rst_set2_state", 32'(state), 32'(LOCKED));
      chk("rst_set2_unlocked", 32'(unlocked), 0);
      #1 rst = 1'b1;
      tick();
      attempt(16'h1234);
      chk("rst_pwd_default", 32'(state), 32'(OPEN));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
